// File: rtl/gpio_pad_pkg.sv
// Shared constants for the GPIO pad controller: register map, bank width, reset values.
// Pure declarations; no timing or flow control of its own.
package gpio_pad_pkg;

  localparam int BANK_W = 32;
  localparam int MAX_IO = 64;

  localparam logic [3:0] IDX_OUT      = 4'd0;
  localparam logic [3:0] IDX_OE       = 4'd1;
  localparam logic [3:0] IDX_CS       = 4'd2;
  localparam logic [3:0] IDX_SL       = 4'd3;
  localparam logic [3:0] IDX_PU       = 4'd4;
  localparam logic [3:0] IDX_PD       = 4'd5;
  localparam logic [3:0] IDX_IE       = 4'd6;
  localparam logic [3:0] IDX_IN       = 4'd7;
  localparam logic [3:0] IDX_RISE_EN  = 4'd8;
  localparam logic [3:0] IDX_FALL_EN  = 4'd9;
  localparam logic [3:0] IDX_IRQ_STAT = 4'd10;
  localparam logic [3:0] IDX_OUT_SET  = 4'd11;
  localparam logic [3:0] IDX_OUT_CLR  = 4'd12;

  // Per-bit reset values: everything clear except input enable.
  localparam logic RST_CFG = 1'b0;
  localparam logic RST_IE  = 1'b1;

endpackage

// File: rtl/gpio_sync.sv
// One pad's input synchroniser plus gated edge detector; edge pulse is registered.
// Latency: pad to gated value SYNC_STAGES-1 edges after sampling, edge pulse one edge later; no backpressure.
module gpio_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad,
  input  logic ie,
  input  logic rise_en,
  input  logic fall_en,
  output logic in_val,
  output logic edge_hit
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   edge_q;

  assign in_val   = sync_q[SYNC_STAGES-1] & ie;
  assign edge_hit = edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      dly_q  <= in_val;
      // Edges are taken on the IE-gated value so a disabled pad never interrupts.
      edge_q <= (in_val & ~dly_q & rise_en) | (~in_val & dly_q & fall_en);
    end
  end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: banked register file driving pad controls, synchronised inputs, edge interrupts.
// Latency: writes act on the strobe edge, reads return one cycle later; always ready, no backpressure.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int NUM_IO      = 43,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              we_i,
  input  logic              re_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oe,
  output logic [NUM_IO-1:0] io_cs,
  output logic [NUM_IO-1:0] io_sl,
  output logic [NUM_IO-1:0] io_pu,
  output logic [NUM_IO-1:0] io_pd,
  output logic [NUM_IO-1:0] io_ie,
  output logic              irq_o,
  output logic              const_one,
  output logic              const_zero
);

  logic [NUM_IO-1:0] out_q, oe_q, cs_q, sl_q, pu_q, pd_q, ie_q;
  logic [NUM_IO-1:0] rise_q, fall_q, stat_q;
  logic [NUM_IO-1:0] in_vec, edge_vec;
  logic [NUM_IO-1:0] wr_mask, ln_mask, stat_clr;
  logic [3:0]        idx;
  logic              bank;
  logic [31:0]       rd_mux;

  assign idx  = addr_i[4:1];
  assign bank = addr_i[0];

  // Place a 32-bit bank word onto pad positions; bits beyond NUM_IO fall away.
  function automatic logic [NUM_IO-1:0] lane_bits(input logic [BANK_W-1:0] d, input logic b);
    logic [NUM_IO-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if ((i >= BANK_W) == b) m[i] = d[i % BANK_W];
    end
    return m;
  endfunction

  function automatic logic [BANK_W-1:0] lane_read(input logic [NUM_IO-1:0] v, input logic b);
    logic [BANK_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if ((i >= BANK_W) == b) r[i % BANK_W] = v[i];
    end
    return r;
  endfunction

  assign wr_mask  = lane_bits(wdata_i, bank);
  assign ln_mask  = lane_bits({BANK_W{1'b1}}, bank);
  assign stat_clr = (we_i && idx == IDX_IRQ_STAT) ? wr_mask : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q  <= {NUM_IO{RST_CFG}};
      oe_q   <= {NUM_IO{RST_CFG}};
      cs_q   <= {NUM_IO{RST_CFG}};
      sl_q   <= {NUM_IO{RST_CFG}};
      pu_q   <= {NUM_IO{RST_CFG}};
      pd_q   <= {NUM_IO{RST_CFG}};
      ie_q   <= {NUM_IO{RST_IE}};
      rise_q <= {NUM_IO{RST_CFG}};
      fall_q <= {NUM_IO{RST_CFG}};
      stat_q <= {NUM_IO{RST_CFG}};
    end else begin
      if (we_i) begin
        case (idx)
          IDX_OUT:     out_q  <= (out_q  & ~ln_mask) | wr_mask;
          IDX_OE:      oe_q   <= (oe_q   & ~ln_mask) | wr_mask;
          IDX_CS:      cs_q   <= (cs_q   & ~ln_mask) | wr_mask;
          IDX_SL:      sl_q   <= (sl_q   & ~ln_mask) | wr_mask;
          IDX_PU:      pu_q   <= (pu_q   & ~ln_mask) | wr_mask;
          IDX_PD:      pd_q   <= (pd_q   & ~ln_mask) | wr_mask;
          IDX_IE:      ie_q   <= (ie_q   & ~ln_mask) | wr_mask;
          IDX_RISE_EN: rise_q <= (rise_q & ~ln_mask) | wr_mask;
          IDX_FALL_EN: fall_q <= (fall_q & ~ln_mask) | wr_mask;
          IDX_OUT_SET: out_q  <= out_q | wr_mask;
          IDX_OUT_CLR: out_q  <= out_q & ~wr_mask;
          default: ;
        endcase
      end
      // A fresh edge beats a concurrent clear on the same bit.
      stat_q <= (stat_q & ~stat_clr) | edge_vec;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_OUT:      rd_mux = lane_read(out_q, bank);
      IDX_OE:       rd_mux = lane_read(oe_q, bank);
      IDX_CS:       rd_mux = lane_read(cs_q, bank);
      IDX_SL:       rd_mux = lane_read(sl_q, bank);
      IDX_PU:       rd_mux = lane_read(pu_q, bank);
      IDX_PD:       rd_mux = lane_read(pd_q, bank);
      IDX_IE:       rd_mux = lane_read(ie_q, bank);
      IDX_IN:       rd_mux = lane_read(in_vec, bank);
      IDX_RISE_EN:  rd_mux = lane_read(rise_q, bank);
      IDX_FALL_EN:  rd_mux = lane_read(fall_q, bank);
      IDX_IRQ_STAT: rd_mux = lane_read(stat_q, bank);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= re_i;
      if (re_i) rdata_o <= rd_mux;
    end
  end

  for (genvar g = 0; g < NUM_IO; g++) begin : g_pad
    gpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pad      (io_in[g]),
      .ie       (ie_q[g]),
      .rise_en  (rise_q[g]),
      .fall_en  (fall_q[g]),
      .in_val   (in_vec[g]),
      .edge_hit (edge_vec[g])
    );
  end

  assign io_out     = out_q;
  assign io_oe      = oe_q;
  assign io_cs      = cs_q;
  assign io_sl      = sl_q;
  assign io_pu      = pu_q;
  assign io_pd      = pd_q & ~pu_q;
  assign io_ie      = ie_q;
  assign irq_o      = |stat_q;
  assign const_one  = 1'b1;
  assign const_zero = 1'b0;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: register-access vector table plus hand sequences for pad timing.
module tb_gpio_pad_ctrl;

  localparam int NUM_IO = 43;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [4:0]        addr_i;
  logic [31:0]       wdata_i;
  logic              we_i;
  logic              re_i;
  logic [31:0]       rdata_o;
  logic              rvalid_o;
  logic [NUM_IO-1:0] io_in;
  logic [NUM_IO-1:0] io_out, io_oe, io_cs, io_sl, io_pu, io_pd, io_ie;
  logic              irq_o;
  logic              const_one;
  logic              const_zero;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  gpio_pad_ctrl #(.NUM_IO(NUM_IO), .SYNC_STAGES(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .we_i       (we_i),
    .re_i       (re_i),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oe      (io_oe),
    .io_cs      (io_cs),
    .io_sl      (io_sl),
    .io_pu      (io_pu),
    .io_pd      (io_pd),
    .io_ie      (io_ie),
    .irq_o      (irq_o),
    .const_one  (const_one),
    .const_zero (const_zero)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive one access, step to the next negedge, check the read port.
  task automatic do_op(input string nm, input vec_t v);
    we_i    = v.we;
    re_i    = v.re;
    addr_i  = v.addr;
    wdata_i = v.wdata;
    @(negedge clk_i);
    we_i = 1'b0;
    re_i = 1'b0;
    chk({nm, "_rvalid"}, 32'(rvalid_o), 32'(v.re));
    if (v.re) chk({nm, "_rdata"}, rdata_o, v.exp);
  endtask

  task automatic wr(input string nm, input logic [4:0] a, input logic [31:0] d);
    do_op(nm, '{we: 1'b1, re: 1'b0, addr: a, wdata: d, exp: 32'h0});
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] e);
    do_op(nm, '{we: 1'b0, re: 1'b1, addr: a, wdata: 32'h0, exp: e});
  endtask

  initial begin
    rst_i   = 1'b1;
    we_i    = 1'b0;
    re_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    io_in   = '0;
    repeat (3) @(negedge clk_i);

    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_out", io_out[31:0], 32'h0);
    chk("rst_oe", io_oe[31:0], 32'h0);
    chk("rst_ie_lo", io_ie[31:0], 32'hFFFF_FFFF);
    chk("rst_ie_hi", 32'(io_ie[42:32]), 32'h7FF);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("const", 32'({const_one, const_zero}), 32'h2);
    rst_i = 1'b0;

    //                 we    re    addr    wdata          expected rdata
    tbl.push_back('{1'b0, 1'b1, 5'd12, 32'h0,         32'hFFFF_FFFF}); // IE bank0
    tbl.push_back('{1'b0, 1'b1, 5'd13, 32'h0,         32'h0000_07FF}); // IE bank1
    tbl.push_back('{1'b0, 1'b1, 5'd0,  32'h0,         32'h0});         // OUT bank0
    tbl.push_back('{1'b1, 1'b0, 5'd0,  32'h0000_000F, 32'h0});         // OUT = F
    tbl.push_back('{1'b1, 1'b0, 5'd22, 32'h0000_0030, 32'h0});         // OUT_SET
    tbl.push_back('{1'b1, 1'b0, 5'd24, 32'h0000_0001, 32'h0});         // OUT_CLR
    tbl.push_back('{1'b0, 1'b1, 5'd0,  32'h0,         32'h0000_003E});
    tbl.push_back('{1'b1, 1'b0, 5'd1,  32'hFFFF_FFFF, 32'h0});         // OUT bank1
    tbl.push_back('{1'b0, 1'b1, 5'd1,  32'h0,         32'h0000_07FF});
    tbl.push_back('{1'b1, 1'b0, 5'd26, 32'hFFFF_FFFF, 32'h0});         // index 13
    tbl.push_back('{1'b0, 1'b1, 5'd26, 32'h0,         32'h0});
    tbl.push_back('{1'b0, 1'b1, 5'd22, 32'h0,         32'h0});         // OUT_SET reads 0
    tbl.push_back('{1'b1, 1'b0, 5'd8,  32'h0000_0001, 32'h0});         // PU
    tbl.push_back('{1'b1, 1'b0, 5'd10, 32'h0000_0003, 32'h0});         // PD
    tbl.push_back('{1'b0, 1'b1, 5'd10, 32'h0,         32'h0000_0003});
    tbl.push_back('{1'b1, 1'b1, 5'd2,  32'h0000_00AA, 32'h0});         // OE rd+wr: old value
    tbl.push_back('{1'b0, 1'b1, 5'd2,  32'h0,         32'h0000_00AA});
    tbl.push_back('{1'b0, 1'b1, 5'd14, 32'h0,         32'h0});         // IN bank0

    for (int i = 0; i < tbl.size(); i++) do_op($sformatf("vec%0d", i), tbl[i]);

    chk("io_out_lo", 32'(io_out[5:0]), 32'h3E);
    chk("io_out_hi", 32'(io_out[42:32]), 32'h7FF);
    chk("io_pu0", 32'(io_pu[0]), 32'h1);
    chk("io_pd10", 32'(io_pd[1:0]), 32'h2);
    chk("io_oe", io_oe[31:0], 32'h0000_00AA);

    // rvalid is a single-cycle pulse and rdata holds afterwards.
    rd("hold_rd", 5'd13, 32'h7FF);
    @(negedge clk_i);
    chk("hold_rvalid", 32'(rvalid_o), 32'h0);
    chk("hold_rdata", rdata_o, 32'h7FF);

    // Rise on pad 40 sampled at edge k: irq after edge k+3, not before.
    wr("rise40_en", 5'd17, 32'h0000_0100);
    io_in[40] = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rise40_k2", 32'(irq_o), 32'h0);
    @(negedge clk_i);
    chk("rise40_k3", 32'(irq_o), 32'h1);
    rd("stat_b1", 5'd21, 32'h0000_0100);
    rd("in_b1", 5'd15, 32'h0000_0100);
    wr("w1c40", 5'd21, 32'h0000_0100);
    chk("w1c40_irq", 32'(irq_o), 32'h0);

    // Fall on pad 2 colliding with a W1C: set must win.
    wr("fall2_en", 5'd18, 32'h0000_0004);
    io_in[2] = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("rise2_noirq", 32'(irq_o), 32'h0);
    io_in[2] = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("fall2_irq", 32'(irq_o), 32'h1);
    io_in[2] = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("fall2_sticky", 32'(irq_o), 32'h1);
    io_in[2] = 1'b0;
    repeat (3) @(negedge clk_i);
    wr("w1c_collide", 5'd20, 32'h0000_0004);
    chk("collide_irq", 32'(irq_o), 32'h1);
    rd("collide_stat", 5'd20, 32'h0000_0004);
    wr("w1c2", 5'd20, 32'h0000_0004);
    chk("w1c2_irq", 32'(irq_o), 32'h0);
    rd("w1c2_stat", 5'd20, 32'h0);

    // Input enable gating on pad 3.
    wr("ie3_off", 5'd12, 32'hFFFF_FFF7);
    wr("rise3_en", 5'd16, 32'h0000_0008);
    io_in[3] = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("ie3_noirq", 32'(irq_o), 32'h0);
    rd("ie3_in", 5'd14, 32'h0);
    wr("ie3_on", 5'd12, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk_i);
    rd("ie3_in_on", 5'd14, 32'h0000_0008);

    // Reset during a concurrent read and write to IE.
    rst_i   = 1'b1;
    we_i    = 1'b1;
    re_i    = 1'b1;
    addr_i  = 5'd12;
    wdata_i = 32'h0;
    @(negedge clk_i);
    we_i = 1'b0;
    re_i = 1'b0;
    chk("rstmid_rvalid", 32'(rvalid_o), 32'h0);
    chk("rstmid_rdata", rdata_o, 32'h0);
    chk("rstmid_ie", io_ie[31:0], 32'hFFFF_FFFF);
    chk("rstmid_irq", 32'(irq_o), 32'h0);
    chk("rstmid_out", io_out[31:0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 Parameter NUM_IO, default 43, number of pads controlled, legal range 1..64.
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth, legal range 2..3.
REQ-003 clk_i  input  1  single clock for all logic.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 addr_i  input  5  word address; [4:1] register index, [0] bank (bank 0 = pads 0..31, bank 1 = pads 32..63).
REQ-006 wdata_i  input  32  write data.
REQ-007 we_i  input  1  write strobe, one write per cycle.
REQ-008 re_i  input  1  read strobe.
REQ-009 rdata_o  output  32  registered read data.
REQ-010 rvalid_o  output  1  read data valid.
REQ-011 io_in  input  NUM_IO  pad input values.
REQ-012 io_out, io_oe, io_cs, io_sl, io_pu, io_pd, io_ie  output  NUM_IO each  pad drive, output enable, schmitt, slew, pull-up, pull-down, input enable.
REQ-013 irq_o  output  1  OR of all pending interrupt status bits.
REQ-014 const_one / const_zero  output  1  tie-high / tie-low.

Function
REQ-015 Register index: 0 OUT, 1 OE, 2 CS, 3 SL, 4 PU, 5 PD, 6 IE, 7 IN (RO), 8 RISE_EN, 9 FALL_EN, 10 IRQ_STAT (W1C), 11 OUT_SET (WO, write-1-set OUT), 12 OUT_CLR (WO, write-1-clear OUT).
REQ-016 Indices 13..15 ignore writes and read 0; bits for pads >= NUM_IO ignore writes and read 0; WO registers read 0.
REQ-017 Writes take effect on the clk_i edge where we_i=1; pad outputs reflect the new value from that edge onward.
REQ-018 Read: re_i=1 at edge k -> rdata_o and rvalid_o=1 valid after edge k; rvalid_o=0 otherwise; rdata_o holds its last value when rvalid_o=0.
REQ-019 re_i and we_i in the same cycle to the same register: read returns the pre-write value.
REQ-020 io_out, io_oe, io_cs, io_sl, io_pu, io_ie driven directly from their registers.
REQ-021 io_pd = PD & ~PU per pad: pull-up wins when both are set.
REQ-022 io_in passes through SYNC_STAGES flops; IN register is the final stage, gated by IE (IE=0 reads 0).
REQ-023 Edge detect on the gated synchronised value vs. its one-cycle-delayed copy: rise = new & ~old & RISE_EN, fall = ~new & old & FALL_EN.
REQ-024 Detected edge sets IRQ_STAT bit on the following edge; bit is sticky until cleared by W1C.
REQ-025 Simultaneous W1C and new edge on same bit: bit remains 1 (set wins).
REQ-026 irq_o registered-free: combinational OR of IRQ_STAT, so it asserts in the same cycle the status bit sets.
REQ-027 Pad toggle sampled at edge k: IN updated after edge k+SYNC_STAGES-1; IRQ_STAT set and irq_o high after edge k+SYNC_STAGES+1.

Reset
REQ-028 rst_i=1 at an edge: OUT, OE, CS, SL, PU, PD, RISE_EN, FALL_EN, IRQ_STAT = 0; IE = all ones; synchroniser and delay flops = 0; rvalid_o = 0; rdata_o = 0.
REQ-029 Reset mid-transaction aborts any read (no rvalid_o) and discards a concurrent write.
REQ-030 RISE_EN = 0 after reset, so no interrupt results from synchroniser fill after reset.

Structure
REQ-031 Shared package gpio_pad_pkg holds register index constants, bank width (32) and reset values.
REQ-032 One sub-module, gpio_sync, implements one pad's synchroniser and edge detector, instantiated NUM_IO times.

Verification
REQ-033 Reset, read IE bank 0 -> 0xFFFFFFFF; bank 1 -> 0x000007FF (NUM_IO=43); OUT bank 0 -> 0; rvalid_o high exactly one cycle after re_i.
REQ-034 Write OUT bank 0 = 0x0000000F; OUT_SET = 0x00000030; OUT_CLR = 0x00000001 -> io_out[5:0] = 6'b111110.
REQ-035 Write PU = 0x1, PD = 0x3 -> io_pu[0]=1, io_pd[0]=0, io_pd[1]=1.
REQ-036 RISE_EN[40]=1, io_in[40] 0->1 at edge k -> IRQ_STAT bank 1 bit 8 set and irq_o=1 after edge k+3; W1C 0x100 -> irq_o=0 next cycle.
REQ-037 W1C on a status bit in the same cycle a new fall edge is detected on it (FALL_EN=1) -> bit stays 1, irq_o stays 1.
REQ-038 IE[3]=0, io_in[3]=1 -> IN bit 3 reads 0, no interrupt with RISE_EN[3]=1.
